multi_issue_station: RTL and testbench

MULTI_ISSUE_STATION -- requirements
Module: multi_issue_station

---
 rtl/ooo_pkg.sv | 22 ++
 rtl/age_matrix_select.sv | 60 ++++++
 rtl/multi_issue_station.sv | 233 +++++++++++++++++++++++
 tb/tb_multi_issue_station.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ooo_pkg.sv
// Shared constants, field widths and branch-event encoding for the
// out-of-order issue stations.
package ooo_pkg;

  localparam int DEF_INST_ID_BIT    = 8;
  localparam int DEF_NUM_REG        = 8;
  localparam int DEF_IMM_BIT        = 4;
  localparam int DEF_SPEC_DEPTH     = 4;
  localparam int DEF_REG_ID_BIT     = $clog2(DEF_NUM_REG);
  localparam int DEF_SPEC_LEVEL_BIT = $clog2(DEF_SPEC_DEPTH) + 1;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_SUCC = 2'd1,
    BR_FAIL = 2'd2
  } br_evt_e;

  typedef logic [DEF_REG_ID_BIT-1:0]     reg_id_t;
  typedef logic [DEF_SPEC_LEVEL_BIT-1:0] spec_level_t;
  typedef logic [DEF_INST_ID_BIT-1:0]    inst_id_t;

endpackage

// File: rtl/age_matrix_select.sv
// Age matrix over the station entries plus k-th-oldest eligible selection.
// r_older[i][j] = 1 means entry i was written before entry j.
module age_matrix_select #(
  parameter int STATION_SIZE = 8,
  parameter int ISSUE_WIDTH  = 2,
  localparam int RANK_BIT    = $clog2(STATION_SIZE + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [STATION_SIZE-1:0]           i_valid,
  input  logic [STATION_SIZE-1:0]           i_elig,
  input  logic [STATION_SIZE-1:0]           i_alloc,
  output logic [ISSUE_WIDTH*STATION_SIZE-1:0] o_grant
);

  logic [STATION_SIZE-1:0] r_older [STATION_SIZE];
  logic [RANK_BIT-1:0]     w_rank  [STATION_SIZE];

  // A new entry is younger than everything currently valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STATION_SIZE; i++) begin
        r_older[i] <= '0;
      end
    end else begin
      for (int w = 0; w < STATION_SIZE; w++) begin
        if (i_alloc[w]) begin
          for (int j = 0; j < STATION_SIZE; j++) begin
            r_older[w][j] <= 1'b0;
            if (j != w) begin
              r_older[j][w] <= i_valid[j];
            end
          end
        end
      end
    end
  end

  // Rank of an eligible entry = number of older eligible entries.
  always_comb begin
    for (int i = 0; i < STATION_SIZE; i++) begin
      w_rank[i] = '0;
      for (int j = 0; j < STATION_SIZE; j++) begin
        if (j != i && i_elig[j] && r_older[j][i]) begin
          w_rank[i] = w_rank[i] + RANK_BIT'(1);
        end
      end
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_slot
      for (gj = 0; gj < STATION_SIZE; gj++) begin : g_ent
        assign o_grant[gi*STATION_SIZE+gj] = i_elig[gj] && (w_rank[gj] == RANK_BIT'(gi));
      end
    end
  endgenerate

endmodule

// File: rtl/multi_issue_station.sv
// Multi-issue reservation station with speculative squash and level remap.
// Define ISSUE_STATION_AGE_ORDER_EN for oldest-first selection; otherwise lowest-index-first.
module multi_issue_station
  import ooo_pkg::*;
#(
  parameter int STATION_SIZE = 8,
  parameter int ISSUE_WIDTH  = 2,
  parameter int INST_ID_BIT  = DEF_INST_ID_BIT,
  parameter int NUM_REG      = DEF_NUM_REG,
  parameter int IMM_BIT      = DEF_IMM_BIT,
  parameter int SPEC_DEPTH   = DEF_SPEC_DEPTH,
  localparam int REG_ID_BIT     = $clog2(NUM_REG),
  localparam int SPEC_LEVEL_BIT = $clog2(SPEC_DEPTH) + 1,
  localparam int CNT_BIT        = $clog2(STATION_SIZE + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_vld,
  output logic                                  in_rdy,
  input  logic [INST_ID_BIT-1:0]                in_id,
  input  logic [REG_ID_BIT-1:0]                 in_dst_reg,
  input  logic [REG_ID_BIT-1:0]                 in_src_reg0,
  input  logic [REG_ID_BIT-1:0]                 in_src_reg1,
  input  logic [IMM_BIT-1:0]                    in_imm,
  input  logic [SPEC_LEVEL_BIT-1:0]             in_spec_level,
  input  logic [NUM_REG-1:0]                    ready_reg_mask,
  output logic [ISSUE_WIDTH-1:0]                out_vld,
  input  logic [ISSUE_WIDTH-1:0]                out_rdy,
  output logic [ISSUE_WIDTH*INST_ID_BIT-1:0]    out_id,
  output logic [ISSUE_WIDTH*REG_ID_BIT-1:0]     out_dst_reg,
  output logic [ISSUE_WIDTH*REG_ID_BIT-1:0]     out_src_reg0,
  output logic [ISSUE_WIDTH*REG_ID_BIT-1:0]     out_src_reg1,
  output logic [ISSUE_WIDTH*IMM_BIT-1:0]        out_imm,
  output logic [ISSUE_WIDTH*SPEC_LEVEL_BIT-1:0] out_spec_level,
  output logic [NUM_REG-1:0]                    pending_read,
  output logic                                  empty,
  output logic [CNT_BIT-1:0]                    count,
  input  logic                                  br_pred_vld,
  input  logic                                  br_pred_succ,
  output logic                                  br_pred_rdy,
  input  logic [SPEC_LEVEL_BIT-1:0]             br_pred_fail_level,
  input  logic [SPEC_LEVEL_BIT*(SPEC_DEPTH+1)-1:0] br_pred_succ_nxt_levels
);

  logic [STATION_SIZE-1:0]   r_valid;
  logic [INST_ID_BIT-1:0]    r_id    [STATION_SIZE];
  logic [REG_ID_BIT-1:0]     r_dst   [STATION_SIZE];
  logic [REG_ID_BIT-1:0]     r_src0  [STATION_SIZE];
  logic [REG_ID_BIT-1:0]     r_src1  [STATION_SIZE];
  logic [IMM_BIT-1:0]        r_imm   [STATION_SIZE];
  logic [SPEC_LEVEL_BIT-1:0] r_level [STATION_SIZE];

  br_evt_e                     w_br_evt;
  logic [CNT_BIT-1:0]          w_count;
  logic [NUM_REG-1:0]          w_pend;
  logic [STATION_SIZE-1:0]     w_squash;
  logic [STATION_SIZE-1:0]     w_src_ok;
  logic [STATION_SIZE-1:0]     w_elig;
  logic [STATION_SIZE-1:0]     w_alloc;
  logic [STATION_SIZE-1:0]     w_alloc_en;
  logic [STATION_SIZE-1:0]     w_issue_free;
  logic                        w_wr;
  logic [SPEC_LEVEL_BIT-1:0]   w_nxt       [SPEC_DEPTH+1];
  logic [SPEC_LEVEL_BIT-1:0]   w_level_vis [STATION_SIZE];
  logic [ISSUE_WIDTH*STATION_SIZE-1:0] w_grant;

  assign br_pred_rdy = 1'b1;

  always_comb begin
    w_br_evt = BR_NONE;
    if (br_pred_vld) begin
      w_br_evt = br_pred_succ ? BR_SUCC : BR_FAIL;
    end
  end

  always_comb begin
    w_count = '0;
    w_pend  = '0;
    for (int i = 0; i < STATION_SIZE; i++) begin
      if (r_valid[i]) begin
        w_count          = w_count + CNT_BIT'(1);
        w_pend[r_src0[i]] = 1'b1;
        w_pend[r_src1[i]] = 1'b1;
      end
    end
  end

  assign count        = w_count;
  assign empty        = (w_count == '0);
  assign pending_read = w_pend;
  // Fullness is judged on the registered count, so an issue this cycle never reopens in_rdy early.
  assign in_rdy       = (w_count < CNT_BIT'(STATION_SIZE));
  assign w_wr         = in_vld && in_rdy;
  assign w_alloc      = ~r_valid & (r_valid + STATION_SIZE'(1));
  assign w_alloc_en   = w_wr ? w_alloc : '0;

  genvar gi;
  generate
    for (gi = 0; gi <= SPEC_DEPTH; gi++) begin : g_nxt
      assign w_nxt[gi] = br_pred_succ_nxt_levels[gi*SPEC_LEVEL_BIT +: SPEC_LEVEL_BIT];
    end

    for (gi = 0; gi < STATION_SIZE; gi++) begin : g_ent
      assign w_squash[gi] = r_valid[gi] && (w_br_evt == BR_FAIL) &&
                            (r_level[gi] >= br_pred_fail_level);
      // A source equal to the entry's own destination does not wait on itself.
      assign w_src_ok[gi] = (ready_reg_mask[r_src0[gi]] || (r_src0[gi] == r_dst[gi])) &&
                            (ready_reg_mask[r_src1[gi]] || (r_src1[gi] == r_dst[gi]));
      assign w_elig[gi]   = r_valid[gi] && !w_squash[gi] && w_src_ok[gi];
      assign w_level_vis[gi] = ((w_br_evt == BR_SUCC) &&
                                (r_level[gi] <= SPEC_LEVEL_BIT'(SPEC_DEPTH))) ?
                               w_nxt[r_level[gi]] : r_level[gi];
    end
  endgenerate

`ifdef ISSUE_STATION_AGE_ORDER_EN
  age_matrix_select #(
    .STATION_SIZE (STATION_SIZE),
    .ISSUE_WIDTH  (ISSUE_WIDTH)
  ) u_age (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (r_valid),
    .i_elig  (w_elig),
    .i_alloc (w_alloc_en),
    .o_grant (w_grant)
  );
`else
  logic [CNT_BIT-1:0] w_idx_rank [STATION_SIZE];

  always_comb begin
    for (int i = 0; i < STATION_SIZE; i++) begin
      w_idx_rank[i] = '0;
      for (int j = 0; j < i; j++) begin
        w_idx_rank[i] = w_idx_rank[i] + CNT_BIT'(w_elig[j]);
      end
    end
  end

  genvar gj;
  generate
    for (gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_idx_slot
      for (gj = 0; gj < STATION_SIZE; gj++) begin : g_idx_ent
        assign w_grant[gi*STATION_SIZE+gj] = w_elig[gj] && (w_idx_rank[gj] == CNT_BIT'(gi));
      end
    end
  endgenerate
`endif

  always_comb begin
    w_issue_free = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      for (int i = 0; i < STATION_SIZE; i++) begin
        w_issue_free[i] = w_issue_free[i] | (w_grant[k*STATION_SIZE+i] & out_rdy[k]);
      end
    end
  end

  generate
    for (gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_slot
      logic                      w_vld_s;
      logic [INST_ID_BIT-1:0]    w_id_s;
      logic [REG_ID_BIT-1:0]     w_dst_s;
      logic [REG_ID_BIT-1:0]     w_src0_s;
      logic [REG_ID_BIT-1:0]     w_src1_s;
      logic [IMM_BIT-1:0]        w_imm_s;
      logic [SPEC_LEVEL_BIT-1:0] w_lvl_s;

      always_comb begin
        w_vld_s  = 1'b0;
        w_id_s   = '0;
        w_dst_s  = '0;
        w_src0_s = '0;
        w_src1_s = '0;
        w_imm_s  = '0;
        w_lvl_s  = '0;
        for (int i = 0; i < STATION_SIZE; i++) begin
          if (w_grant[gi*STATION_SIZE+i]) begin
            w_vld_s  = 1'b1;
            w_id_s   = r_id[i];
            w_dst_s  = r_dst[i];
            w_src0_s = r_src0[i];
            w_src1_s = r_src1[i];
            w_imm_s  = r_imm[i];
            w_lvl_s  = w_level_vis[i];
          end
        end
      end

      assign out_vld[gi]                                        = w_vld_s;
      assign out_id[gi*INST_ID_BIT +: INST_ID_BIT]              = w_id_s;
      assign out_dst_reg[gi*REG_ID_BIT +: REG_ID_BIT]           = w_dst_s;
      assign out_src_reg0[gi*REG_ID_BIT +: REG_ID_BIT]          = w_src0_s;
      assign out_src_reg1[gi*REG_ID_BIT +: REG_ID_BIT]          = w_src1_s;
      assign out_imm[gi*IMM_BIT +: IMM_BIT]                     = w_imm_s;
      assign out_spec_level[gi*SPEC_LEVEL_BIT +: SPEC_LEVEL_BIT] = w_lvl_s;
    end
  endgenerate

  // Entry update: the written slot was free, so it is untouched by issue, squash or remap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < STATION_SIZE; i++) begin
        r_id[i]    <= '0;
        r_dst[i]   <= '0;
        r_src0[i]  <= '0;
        r_src1[i]  <= '0;
        r_imm[i]   <= '0;
        r_level[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STATION_SIZE; i++) begin
        if (w_alloc_en[i]) begin
          r_valid[i] <= 1'b1;
          r_id[i]    <= in_id;
          r_dst[i]   <= in_dst_reg;
          r_src0[i]  <= in_src_reg0;
          r_src1[i]  <= in_src_reg1;
          r_imm[i]   <= in_imm;
          r_level[i] <= in_spec_level;
        end else if (w_issue_free[i] || w_squash[i]) begin
          r_valid[i] <= 1'b0;
          r_src0[i]  <= '0;
          r_src1[i]  <= '0;
        end else if (r_valid[i] && (w_br_evt == BR_SUCC)) begin
          r_level[i] <= w_level_vis[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_issue_station.sv
// Scoreboard bench for multi_issue_station: a queue/array reference model predicts
// every cycle's outputs; a negedge monitor pops and compares them.
module tb_multi_issue_station;

  localparam int SS   = 4;
  localparam int IW   = 2;
  localparam int IDB  = 8;
  localparam int NR   = 8;
  localparam int IMMB = 4;
  localparam int SD   = 4;
  localparam int RB   = 3;
  localparam int LB   = 3;
  localparam int CB   = 3;
  localparam int PW   = IDB + 3*RB + IMMB + LB;

  logic                 clk;
  logic                 rst_n;
  logic                 in_vld;
  logic                 in_rdy;
  logic [IDB-1:0]       in_id;
  logic [RB-1:0]        in_dst_reg, in_src_reg0, in_src_reg1;
  logic [IMMB-1:0]      in_imm;
  logic [LB-1:0]        in_spec_level;
  logic [NR-1:0]        ready_reg_mask;
  logic [IW-1:0]        out_vld, out_rdy;
  logic [IW*IDB-1:0]    out_id;
  logic [IW*RB-1:0]     out_dst_reg, out_src_reg0, out_src_reg1;
  logic [IW*IMMB-1:0]   out_imm;
  logic [IW*LB-1:0]     out_spec_level;
  logic [NR-1:0]        pending_read;
  logic                 empty;
  logic [CB-1:0]        count;
  logic                 br_pred_vld, br_pred_succ, br_pred_rdy;
  logic [LB-1:0]        br_pred_fail_level;
  logic [LB*(SD+1)-1:0] br_pred_succ_nxt_levels;

  multi_issue_station #(
    .STATION_SIZE(SS), .ISSUE_WIDTH(IW), .INST_ID_BIT(IDB),
    .NUM_REG(NR), .IMM_BIT(IMMB), .SPEC_DEPTH(SD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_id(in_id), .in_dst_reg(in_dst_reg),
    .in_src_reg0(in_src_reg0), .in_src_reg1(in_src_reg1), .in_imm(in_imm),
    .in_spec_level(in_spec_level), .ready_reg_mask(ready_reg_mask),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_id(out_id), .out_dst_reg(out_dst_reg),
    .out_src_reg0(out_src_reg0), .out_src_reg1(out_src_reg1), .out_imm(out_imm),
    .out_spec_level(out_spec_level), .pending_read(pending_read), .empty(empty),
    .count(count), .br_pred_vld(br_pred_vld), .br_pred_succ(br_pred_succ),
    .br_pred_rdy(br_pred_rdy), .br_pred_fail_level(br_pred_fail_level),
    .br_pred_succ_nxt_levels(br_pred_succ_nxt_levels)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic           in_vld;
    logic [IDB-1:0] id;
    logic [RB-1:0]  dst, s0, s1;
    logic [IMMB-1:0] imm;
    logic [LB-1:0]  lvl;
    logic [NR-1:0]  rdy;
    logic [IW-1:0]  ordy;
    logic           br_vld, br_succ;
    logic [LB-1:0]  fail;
    logic [LB*(SD+1)-1:0] nxt;
  } stim_t;

  typedef struct packed {
    logic [IW-1:0]    vld;
    logic [IW*PW-1:0] pay;
    logic             in_rdy;
    logic [CB-1:0]    cnt;
    logic             empty;
    logic [NR-1:0]    pend;
    logic             br_rdy;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: one record per station position plus an insertion stamp.
  bit   m_vld [SS];
  int   m_id [SS], m_dst [SS], m_s0 [SS], m_s1 [SS], m_imm [SS], m_lvl [SS], m_seq [SS];
  int   seq_ctr;
  int   m_ord [SS];
  int   m_n;
  stim_t prev, idle;
  bit    have_prev;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  function automatic int nxt_of(input stim_t s, input int lvl);
    return int'(s.nxt[lvl*LB +: LB]);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < SS; i++) begin
      m_vld[i] = 0; m_s0[i] = 0; m_s1[i] = 0; m_seq[i] = 0;
    end
    seq_ctr = 0;
  endfunction

  // Eligible entries listed in selection order (by stamp or by position).
  function automatic void build_order(input stim_t s);
    bit e [SS];
    bit used [SS];
    int best;
    m_n = 0;
    for (int i = 0; i < SS; i++) begin
      used[i] = 0;
      e[i] = m_vld[i] && !(s.br_vld && !s.br_succ && m_lvl[i] >= int'(s.fail)) &&
             (s.rdy[m_s0[i]] || m_s0[i] == m_dst[i]) &&
             (s.rdy[m_s1[i]] || m_s1[i] == m_dst[i]);
    end
    for (int r = 0; r < SS; r++) begin
      best = -1;
      for (int i = 0; i < SS; i++) begin
        if (e[i] && !used[i]) begin
`ifdef ISSUE_STATION_AGE_ORDER_EN
          if (best < 0 || m_seq[i] < m_seq[best]) best = i;
`else
          if (best < 0) best = i;
`endif
        end
      end
      if (best >= 0) begin
        used[best] = 1;
        m_ord[m_n] = best;
        m_n++;
      end
    end
  endfunction

  function automatic exp_t expect_of(input stim_t s);
    exp_t e;
    int   cnt, idx, lvl;
    e = '0;
    cnt = 0;
    for (int i = 0; i < SS; i++) begin
      if (m_vld[i]) begin
        cnt++;
        e.pend[m_s0[i]] = 1'b1;
        e.pend[m_s1[i]] = 1'b1;
      end
    end
    e.cnt    = CB'(cnt);
    e.in_rdy = (cnt < SS);
    e.empty  = (cnt == 0);
    e.br_rdy = 1'b1;
    build_order(s);
    for (int k = 0; k < IW; k++) begin
      if (k < m_n) begin
        idx = m_ord[k];
        lvl = (s.br_vld && s.br_succ) ? nxt_of(s, m_lvl[idx]) : m_lvl[idx];
        e.vld[k] = 1'b1;
        e.pay[k*PW +: PW] = {IDB'(m_id[idx]), RB'(m_dst[idx]), RB'(m_s0[idx]),
                             RB'(m_s1[idx]), IMMB'(m_imm[idx]), LB'(lvl)};
      end
    end
    return e;
  endfunction

  function automatic void model_update(input stim_t s);
    int cnt, ws;
    cnt = 0; ws = -1;
    for (int i = 0; i < SS; i++) if (m_vld[i]) cnt++;
    if (s.in_vld && cnt < SS) begin
      for (int i = SS-1; i >= 0; i--) if (!m_vld[i]) ws = i;
    end
    build_order(s);
    for (int k = 0; k < IW && k < m_n; k++) begin
      if (s.ordy[k]) begin
        m_vld[m_ord[k]] = 0; m_s0[m_ord[k]] = 0; m_s1[m_ord[k]] = 0;
      end
    end
    for (int i = 0; i < SS; i++) begin
      if (m_vld[i] && s.br_vld && !s.br_succ && m_lvl[i] >= int'(s.fail)) begin
        m_vld[i] = 0; m_s0[i] = 0; m_s1[i] = 0;
      end else if (m_vld[i] && s.br_vld && s.br_succ) begin
        m_lvl[i] = nxt_of(s, m_lvl[i]);
      end
    end
    if (ws >= 0) begin
      m_vld[ws] = 1; m_id[ws] = int'(s.id); m_dst[ws] = int'(s.dst);
      m_s0[ws] = int'(s.s0); m_s1[ws] = int'(s.s1); m_imm[ws] = int'(s.imm);
      m_lvl[ws] = int'(s.lvl); m_seq[ws] = seq_ctr; seq_ctr++;
    end
  endfunction

  task automatic apply(input stim_t s);
    in_vld = s.in_vld; in_id = s.id; in_dst_reg = s.dst; in_src_reg0 = s.s0;
    in_src_reg1 = s.s1; in_imm = s.imm; in_spec_level = s.lvl;
    ready_reg_mask = s.rdy; out_rdy = s.ordy; br_pred_vld = s.br_vld;
    br_pred_succ = s.br_succ; br_pred_fail_level = s.fail;
    br_pred_succ_nxt_levels = s.nxt;
  endtask

  function automatic stim_t mk(input bit v, input int id, input int dst, input int s0,
                               input int s1, input int lvl, input logic [NR-1:0] rdy,
                               input logic [IW-1:0] ordy);
    stim_t s;
    s = '0;
    s.in_vld = v; s.id = IDB'(id); s.dst = RB'(dst); s.s0 = RB'(s0); s.s1 = RB'(s1);
    s.imm = IMMB'(id); s.lvl = LB'(lvl); s.rdy = rdy; s.ordy = ordy;
    for (int i = 0; i <= SD; i++) s.nxt[i*LB +: LB] = LB'(i);
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s = mk($urandom_range(0, 9) < 7, $urandom_range(0, 255), $urandom_range(0, 7),
           $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, SD), '0,
           IW'($urandom_range(0, 3)));
    for (int r = 0; r < NR; r++) s.rdy[r] = ($urandom_range(0, 3) != 0);
    s.br_vld  = ($urandom_range(0, 7) == 0);
    s.br_succ = $urandom_range(0, 1) == 1;
    s.fail    = LB'($urandom_range(0, SD));
    for (int i = 0; i <= SD; i++) s.nxt[i*LB +: LB] = LB'($urandom_range(0, SD));
    return s;
  endfunction

  task automatic step(input stim_t s);
    @(posedge clk); #1;
    if (have_prev) model_update(prev);
    apply(s);
    exp_q.push_back(expect_of(s));
    prev = s;
    have_prev = 1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    apply(idle);
    #1;
    check("rst_async_out_vld", 64'(out_vld), 64'd0);
    check("rst_async_pending_read", 64'(pending_read), 64'd0);
    model_clear();
    exp_q.push_back(expect_of(idle));
    have_prev = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.push_back(expect_of(idle));
    prev = idle;
    have_prev = 1;
  endtask

  // Monitor: compares whatever the DUT presents against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_vld", 64'(out_vld), 64'(e.vld));
        check("in_rdy", 64'(in_rdy), 64'(e.in_rdy));
        check("count", 64'(count), 64'(e.cnt));
        check("empty", 64'(empty), 64'(e.empty));
        check("pending_read", 64'(pending_read), 64'(e.pend));
        check("br_pred_rdy", 64'(br_pred_rdy), 64'(e.br_rdy));
        for (int k = 0; k < IW; k++) begin
          if (e.vld[k]) begin
            check($sformatf("slot%0d_payload", k),
                  64'({out_id[k*IDB +: IDB], out_dst_reg[k*RB +: RB], out_src_reg0[k*RB +: RB],
                       out_src_reg1[k*RB +: RB], out_imm[k*IMMB +: IMMB],
                       out_spec_level[k*LB +: LB]}),
                  64'(e.pay[k*PW +: PW]));
            if (out_rdy[k])
              $display("[TB] %0t issue slot%0d id=%0d lvl=%0d", $time, k,
                       out_id[k*IDB +: IDB], out_spec_level[k*LB +: LB]);
          end
        end
      end
    end
  end

  initial begin
    stim_t s;
    int    wait_cyc;
    idle = mk(0, 0, 0, 0, 0, 0, '1, '0);
    rst_n = 1'b0;
    apply(idle);
    model_clear();
    have_prev = 0;
    do_reset();

    // Three writes, all sources ready; hold, accept both slots, then the third.
    step(mk(1, 1, 1, 2, 3, 0, '1, 2'b00));
    step(mk(1, 2, 2, 3, 4, 0, '1, 2'b00));
    step(mk(1, 3, 3, 4, 5, 0, '1, 2'b00));
    step(mk(0, 0, 0, 0, 0, 0, '1, 2'b11));
    step(mk(0, 0, 0, 0, 0, 0, '1, 2'b00));
    step(mk(0, 0, 0, 0, 0, 0, '1, 2'b01));
    do_reset();

    // Id1 waits on register 5; ids 2 and 3 go first.
    step(mk(1, 1, 1, 5, 2, 0, 8'hDF, 2'b00));
    step(mk(1, 2, 2, 3, 4, 0, 8'hDF, 2'b00));
    step(mk(1, 3, 3, 4, 6, 0, 8'hDF, 2'b00));
    step(mk(0, 0, 0, 0, 0, 0, 8'hDF, 2'b11));
    step(mk(0, 0, 0, 0, 0, 0, 8'hDF, 2'b00));
    step(mk(0, 0, 0, 0, 0, 0, 8'hFF, 2'b01));
    do_reset();

    // Fill, then write while full and accept only slot 1.
    for (int i = 0; i < SS; i++) step(mk(1, 10+i, i, i, i, 0, '1, 2'b00));
    step(mk(1, 20, 0, 1, 1, 0, '1, 2'b10));
    step(mk(1, 21, 0, 1, 1, 0, '1, 2'b00));
    step(mk(0, 0, 0, 0, 0, 0, '1, 2'b00));
    do_reset();

    // Levels 0,1,2 then squash from level 1 with a simultaneous level-2 write.
    step(mk(1, 30, 1, 1, 1, 0, 8'h00, 2'b00));
    step(mk(1, 31, 2, 2, 2, 1, 8'h00, 2'b00));
    step(mk(1, 32, 3, 3, 3, 2, 8'h00, 2'b00));
    s = mk(1, 33, 4, 4, 4, 2, 8'h00, 2'b00);
    s.br_vld = 1; s.br_succ = 0; s.fail = 3'd1;
    step(s);
    step(mk(0, 0, 0, 0, 0, 0, 8'h00, 2'b00));
    // Success remapping level 2 -> 1, seen in the same cycle and afterwards.
    s = mk(0, 0, 0, 0, 0, 0, '1, 2'b00);
    s.br_vld = 1; s.br_succ = 1; s.nxt[2*LB +: LB] = 3'd1;
    step(s);
    step(mk(0, 0, 0, 0, 0, 0, '1, 2'b00));
    step(mk(0, 0, 0, 0, 0, 0, '1, 2'b11));
    step(mk(1, 40, 1, 2, 3, 0, '1, 2'b00));
    step(mk(1, 41, 1, 2, 3, 0, '1, 2'b01));

    // Mid-issue reset, then randomized traffic with periodic resets.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      step(rand_stim());
      if (n % 500 == 499) do_reset();
    end
    step(idle);

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (exp_q.size() > 0) check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
